// File: rtl/sensor_conditioner_pkg.sv
// sensor_conditioner_pkg: side-light encodings and request FSM states
package sensor_conditioner_pkg;
  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;
  typedef enum logic [1:0] {IDLE = 2'b00, REQUEST = 2'b01, GRANTED = 2'b10} state_t;
endpackage

// File: rtl/sensor_conditioner_debounce_filter.sv
// debounce_filter: two-flop synchronizer followed by a consecutive-cycle debouncer
module debounce_filter #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise
);
  logic sync1, sync2, hit;
  logic [7:0] cnt;
  // rise is asserted in the cycle before dout goes high, so the owner can act on the same edge
  assign hit  = (sync2 != dout) && (cnt == 8'(DEBOUNCE_CYCLES - 1));
  assign rise = hit && !dout;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      dout  <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      cnt   <= (sync2 == dout || hit) ? '0 : cnt + 8'd1;
      if (hit) dout <= ~dout;
    end
  end
endmodule

// File: rtl/sensor_conditioner.sv
// sensor_conditioner: debounced loop detector driving a latched side-road request and arrival counter
module sensor_conditioner
  import sensor_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int COUNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               raw_sensor,
  input  logic [1:0]         side_light,
  output logic               sensor,
  output logic [COUNT_W-1:0] vehicle_count,
  output logic               stable
);
  state_t state, state_n;
  logic sensor_n, rise, green;
  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk (clk),
    .rst (rst),
    .din (raw_sensor),
    .dout(stable),
    .rise(rise)
  );
  assign green = side_light == GREEN;
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:    state_n = rise ? REQUEST : IDLE;
      REQUEST: state_n = green ? GRANTED : REQUEST;
      GRANTED: state_n = green ? GRANTED : (stable || rise) ? REQUEST : IDLE;
      default: state_n = IDLE;
    endcase
    sensor_n = (state_n == REQUEST) || (state_n == GRANTED && stable);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      sensor        <= 1'b0;
      vehicle_count <= '0;
    end else begin
      state  <= state_n;
      sensor <= sensor_n;
      if (rise && !(&vehicle_count)) vehicle_count <= vehicle_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_sensor_conditioner.sv
// tb_sensor_conditioner: directed scenario tasks with hand-computed expectations
module tb_sensor_conditioner;
  import sensor_conditioner_pkg::*;
  logic clk = 1'b0, rst = 1'b0, raw_sensor = 1'b0;
  logic [1:0] side_light = RED;
  logic sensor, stable;
  logic [7:0] vehicle_count;
  int n_vec = 0, n_err = 0;
  sensor_conditioner dut (
    .clk(clk), .rst(rst), .raw_sensor(raw_sensor), .side_light(side_light),
    .sensor(sensor), .vehicle_count(vehicle_count), .stable(stable)
  );
  always #5 clk = ~clk;
  task automatic apply_reset;
    rst = 1'b0; raw_sensor = 1'b0; side_light = RED;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
  endtask
  task automatic test_reset;
    #20 rst = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      n_vec++;
      if ({sensor, stable, vehicle_count} !== 10'd0) begin
        n_err++;
        $display("FAIL reset_hold t=%0t sensor=%b stable=%b count=%0d want 0/0/0", $time, sensor, stable, vehicle_count);
      end
    end
  endtask
  task automatic test_glitch;
    apply_reset;
    raw_sensor = 1'b1;
    repeat (3) @(negedge clk);
    raw_sensor = 1'b0;
    repeat (10) @(negedge clk);
    n_vec++;
    if ({sensor, stable, vehicle_count} !== 10'd0) begin
      n_err++;
      $display("FAIL glitch sensor=%b stable=%b count=%0d want 0/0/0", sensor, stable, vehicle_count);
    end
  endtask
  task automatic test_arrival;
    apply_reset;
    raw_sensor = 1'b1;
    repeat (5) @(posedge clk);
    #1 n_vec++;
    if (stable !== 1'b0 || sensor !== 1'b0) begin
      n_err++;
      $display("FAIL arrival_early stable=%b sensor=%b want 0/0", stable, sensor);
    end
    @(posedge clk);
    #1 n_vec++;
    if (stable !== 1'b1 || sensor !== 1'b1 || vehicle_count !== 8'd1 || dut.state !== REQUEST) begin
      n_err++;
      $display("FAIL arrival_edge6 stable=%b sensor=%b count=%0d state=%0d want 1/1/1/%0d", stable, sensor, vehicle_count, dut.state, REQUEST);
    end
  endtask
  task automatic test_latched;
    apply_reset;
    raw_sensor = 1'b1;
    repeat (10) @(negedge clk);
    raw_sensor = 1'b0;
    repeat (12) @(negedge clk);
    n_vec++;
    if (stable !== 1'b0 || sensor !== 1'b1 || dut.state !== REQUEST || vehicle_count !== 8'd1) begin
      n_err++;
      $display("FAIL latched stable=%b sensor=%b state=%0d count=%0d want 0/1/%0d/1", stable, sensor, dut.state, vehicle_count, REQUEST);
    end
    side_light = GREEN;
    @(negedge clk);
    n_vec++;
    if (dut.state !== GRANTED || sensor !== 1'b0) begin
      n_err++;
      $display("FAIL latched_green state=%0d sensor=%b want %0d/0", dut.state, sensor, GRANTED);
    end
    side_light = RED;
    @(negedge clk);
    n_vec++;
    if (dut.state !== IDLE || sensor !== 1'b0) begin
      n_err++;
      $display("FAIL latched_release state=%0d sensor=%b want %0d/0", dut.state, sensor, IDLE);
    end
  endtask
  task automatic test_granted;
    apply_reset;
    raw_sensor = 1'b1;
    repeat (8) @(negedge clk);
    side_light = 2'b11;
    @(negedge clk);
    n_vec++;
    if (dut.state !== REQUEST || sensor !== 1'b1) begin
      n_err++;
      $display("FAIL undefined_light state=%0d sensor=%b want %0d/1", dut.state, sensor, REQUEST);
    end
    side_light = GREEN;
    repeat (2) @(negedge clk);
    n_vec++;
    if (dut.state !== GRANTED || sensor !== 1'b1) begin
      n_err++;
      $display("FAIL granted_high state=%0d sensor=%b want %0d/1", dut.state, sensor, GRANTED);
    end
    raw_sensor = 1'b0;
    repeat (8) @(negedge clk);
    n_vec++;
    if (dut.state !== GRANTED || sensor !== 1'b0 || stable !== 1'b0) begin
      n_err++;
      $display("FAIL granted_low state=%0d sensor=%b stable=%b want %0d/0/0", dut.state, sensor, stable, GRANTED);
    end
    raw_sensor = 1'b1;
    repeat (8) @(negedge clk);
    n_vec++;
    if (dut.state !== GRANTED || sensor !== 1'b1 || vehicle_count !== 8'd2) begin
      n_err++;
      $display("FAIL granted_rearrive state=%0d sensor=%b count=%0d want %0d/1/2", dut.state, sensor, vehicle_count, GRANTED);
    end
    side_light = YELLOW;
    @(negedge clk);
    n_vec++;
    if (dut.state !== REQUEST || sensor !== 1'b1) begin
      n_err++;
      $display("FAIL granted_exit state=%0d sensor=%b want %0d/1", dut.state, sensor, REQUEST);
    end
    side_light = RED;
  endtask
  task automatic test_saturation;
    apply_reset;
    for (int i = 1; i <= 260; i++) begin
      raw_sensor = 1'b1;
      repeat (8) @(negedge clk);
      raw_sensor = 1'b0;
      repeat (8) @(negedge clk);
      if (i == 100 || i == 255 || i == 260) begin
        n_vec++;
        if (vehicle_count !== ((i > 255) ? 8'd255 : 8'(i))) begin
          n_err++;
          $display("FAIL saturation pulses=%0d count=%0d want %0d", i, vehicle_count, (i > 255) ? 255 : i);
        end
      end
    end
  endtask
  task automatic test_async_reset;
    apply_reset;
    raw_sensor = 1'b1;
    repeat (8) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 n_vec++;
    if ({sensor, stable, vehicle_count} !== 10'd0 || dut.state !== IDLE) begin
      n_err++;
      $display("FAIL async_reset sensor=%b stable=%b count=%0d state=%0d want 0/0/0/%0d", sensor, stable, vehicle_count, dut.state, IDLE);
    end
    raw_sensor = 1'b0;
  endtask
  initial begin
    test_reset;
    test_glitch;
    test_arrival;
    test_latched;
    test_granted;
    test_saturation;
    test_async_reset;
    test_arrival;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
